coin_counter: RTL and testbench

COIN_COUNTER -- requirements
Module: coin_counter

---
 rtl/coin_pkg.sv | 36 +++
 rtl/coin_lane.sv | 94 +++++++++
 rtl/coin_counter.sv | 73 +++++++
 tb/tb_coin_counter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared constants for the coin counter: lane indices, denominations, lane FSM encoding.
// No timing or flow control; definitions only.
package coin_pkg;

   localparam int NUM_LANES = 4;

   localparam int LANE_1C  = 0;
   localparam int LANE_5C  = 1;
   localparam int LANE_10C = 2;
   localparam int LANE_25C = 3;

   localparam logic [5:0] CENTS_1C  = 6'd1;
   localparam logic [5:0] CENTS_5C  = 6'd5;
   localparam logic [5:0] CENTS_10C = 6'd10;
   localparam logic [5:0] CENTS_25C = 6'd25;

   localparam int unsigned DEBOUNCE_DEFAULT = 30000;
   localparam int unsigned JAM_DEFAULT      = 15000000;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_FALL_CHK = 2'd1;
   localparam logic [1:0] ST_BROKEN   = 2'd2;
   localparam logic [1:0] ST_RISE_CHK = 2'd3;

   // Value in cents of all lanes pulsing in one cycle (max 41).
   function automatic logic [5:0] event_cents(input logic [3:0] ev);
      logic [5:0] sum;
      sum = 6'd0;
      if (ev[LANE_1C])  sum = sum + CENTS_1C;
      if (ev[LANE_5C])  sum = sum + CENTS_5C;
      if (ev[LANE_10C]) sum = sum + CENTS_10C;
      if (ev[LANE_25C]) sum = sum + CENTS_25C;
      return sum;
   endfunction

endpackage

// File: rtl/coin_lane.sv
// One beam lane: 2-flop sync, debounce FSM, jam timer; event 2+DEBOUNCE_CYCLES after the fall.
// No backpressure: coin_event is a one-cycle pulse that must be consumed when it fires.
module coin_lane
   import coin_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int unsigned JAM_CYCLES      = JAM_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic beam_raw,
   output logic coin_event,
   output logic jam
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int JM_W = $clog2(JAM_CYCLES + 1);
   // The cycle that moves IDLE/BROKEN into a check state is the first stable cycle.
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 2);
   localparam logic [JM_W-1:0] JM_MAX  = JM_W'(JAM_CYCLES);
   localparam logic [JM_W-1:0] JM_LAST = JM_W'(JAM_CYCLES - 1);

   logic            sync1;
   logic            sync2;
   logic [1:0]      state;
   logic [DB_W-1:0] db_cnt;
   logic [JM_W-1:0] jam_cnt;
   logic            jam_tick;

   always_comb begin
      jam_tick = 1'b0;
      if ((state == ST_BROKEN || state == ST_RISE_CHK) && !sync2) jam_tick = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1      <= 1'b1;
         sync2      <= 1'b1;
         state      <= ST_IDLE;
         db_cnt     <= '0;
         jam_cnt    <= '0;
         coin_event <= 1'b0;
         jam        <= 1'b0;
      end else begin
         sync1      <= beam_raw;
         sync2      <= sync1;
         coin_event <= 1'b0;

         if (jam_tick && jam_cnt != JM_MAX) begin
            jam_cnt <= jam_cnt + JM_W'(1);
            if (jam_cnt == JM_LAST) jam <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (!sync2) begin
                  state  <= ST_FALL_CHK;
                  db_cnt <= '0;
               end
            end
            ST_FALL_CHK: begin
               if (sync2) begin
                  state <= ST_IDLE;
               end else if (db_cnt == DB_LAST) begin
                  state      <= ST_BROKEN;
                  coin_event <= 1'b1;
                  jam_cnt    <= '0;
               end else begin
                  db_cnt <= db_cnt + DB_W'(1);
               end
            end
            ST_BROKEN: begin
               if (sync2) begin
                  state  <= ST_RISE_CHK;
                  db_cnt <= '0;
               end
            end
            ST_RISE_CHK: begin
               if (!sync2) begin
                  state <= ST_BROKEN;
               end else if (db_cnt == DB_LAST) begin
                  state   <= ST_IDLE;
                  jam     <= 1'b0;
                  jam_cnt <= '0;
               end else begin
                  db_cnt <= db_cnt + DB_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/coin_counter.sv
// Four debounced coin lanes with saturating per-lane counts, cents total and sticky pending flags.
// Counts/total/pending update one cycle after coin_event; no backpressure, ack only clears pending.
module coin_counter
   import coin_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int unsigned JAM_CYCLES      = JAM_DEFAULT,
   parameter int          CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       beam_raw,
   input  logic [3:0]       ack,
   input  logic             clear,
   output logic [3:0]       coin_event,
   output logic [3:0]       pending,
   output logic [3:0]       jam,
   output logic [CNT_W-1:0] count_1,
   output logic [CNT_W-1:0] count_5,
   output logic [CNT_W-1:0] count_10,
   output logic [CNT_W-1:0] count_25,
   output logic [31:0]      total_cents
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q [NUM_LANES];
   logic [31:0]      total_base;
   logic [32:0]      total_sum;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      coin_lane #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .JAM_CYCLES      (JAM_CYCLES)
      ) u_lane (
         .clk        (clk),
         .rst_n      (rst_n),
         .beam_raw   (beam_raw[i]),
         .coin_event (coin_event[i]),
         .jam        (jam[i])
      );
   end

   // A clear in the same cycle as an event still keeps that event's value.
   always_comb begin
      total_base = clear ? 32'd0 : total_cents;
      total_sum  = {1'b0, total_base} + 33'(event_cents(coin_event));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int l = 0; l < NUM_LANES; l++) cnt_q[l] <= '0;
         total_cents <= 32'd0;
         pending     <= 4'd0;
      end else begin
         for (int l = 0; l < NUM_LANES; l++) begin
            if (clear) begin
               cnt_q[l] <= coin_event[l] ? CNT_W'(1) : '0;
            end else if (coin_event[l] && cnt_q[l] != CNT_MAX) begin
               cnt_q[l] <= cnt_q[l] + CNT_W'(1);
            end
         end
         total_cents <= total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];
         pending     <= coin_event | (pending & ~ack);
      end
   end

   assign count_1  = cnt_q[LANE_1C];
   assign count_5  = cnt_q[LANE_5C];
   assign count_10 = cnt_q[LANE_10C];
   assign count_25 = cnt_q[LANE_25C];

endmodule

// File: tb/tb_coin_counter.sv
// Bench for coin_counter: directed scenarios plus random beam waveforms against a
// level-acceptance reference model (a level is accepted after DB stable synced samples).
module tb_coin_counter;

   localparam int DB = 4;
   localparam int JM = 20;
   localparam int W  = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   beam_raw = 4'hF;
   logic [3:0]   ack = 4'h0;
   logic         clear = 1'b0;
   logic [3:0]   coin_event, pending, jam;
   logic [W-1:0] count_1, count_5, count_10, count_25;
   logic [31:0]  total_cents;

   coin_counter #(.DEBOUNCE_CYCLES(DB), .JAM_CYCLES(JM), .CNT_W(W)) dut (
      .clk(clk), .rst_n(rst_n), .beam_raw(beam_raw), .ack(ack), .clear(clear),
      .coin_event(coin_event), .pending(pending), .jam(jam),
      .count_1(count_1), .count_5(count_5), .count_10(count_10), .count_25(count_25),
      .total_cents(total_cents)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   int          value_c[4] = '{1, 5, 10, 25};
   logic [3:0]  m_s1, m_s2, m_acc, m_ev, m_jam, m_pend;
   int          m_run[4], m_jc[4], m_cnt[4];
   longint      m_total;
   int          ev_tally[4];

   task automatic model_reset();
      m_s1 = 4'hF; m_s2 = 4'hF; m_acc = 4'hF;
      m_ev = 4'h0; m_jam = 4'h0; m_pend = 4'h0;
      m_total = 0;
      for (int i = 0; i < 4; i++) begin
         m_run[i] = 0; m_jc[i] = 0; m_cnt[i] = 0;
      end
   endtask

   task automatic model_step();
      logic [3:0] new_ev;
      logic       lvl;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (clear) begin
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
         m_total = 0;
      end
      for (int i = 0; i < 4; i++) begin
         if (m_ev[i]) begin
            if (m_cnt[i] < (1 << W) - 1) m_cnt[i]++;
            m_total += value_c[i];
            m_pend[i] = 1'b1;
         end else if (ack[i]) begin
            m_pend[i] = 1'b0;
         end
      end
      if (m_total > 64'hFFFF_FFFF) m_total = 64'hFFFF_FFFF;
      new_ev = 4'h0;
      for (int i = 0; i < 4; i++) begin
         lvl = m_s2[i];
         if (!m_acc[i] && !lvl && m_jc[i] < JM) m_jc[i]++;
         if (lvl != m_acc[i]) begin
            m_run[i]++;
            if (m_run[i] == DB) begin
               m_acc[i] = lvl;
               m_run[i] = 0;
               m_jc[i]  = 0;
               if (!lvl) new_ev[i] = 1'b1;
            end
         end else begin
            m_run[i] = 0;
         end
         m_jam[i] = !m_acc[i] && (m_jc[i] >= JM);
      end
      m_s2 = m_s1;
      m_s1 = beam_raw;
      m_ev = new_ev;
   endtask

   task automatic compare_all();
      check("coin_event", 32'(coin_event), 32'(m_ev));
      check("pending", 32'(pending), 32'(m_pend));
      check("jam", 32'(jam), 32'(m_jam));
      check("count_1", 32'(count_1), 32'(m_cnt[0]));
      check("count_5", 32'(count_5), 32'(m_cnt[1]));
      check("count_10", 32'(count_10), 32'(m_cnt[2]));
      check("count_25", 32'(count_25), 32'(m_cnt[3]));
      check("total_cents", total_cents, 32'(m_total));
   endtask

   // Called at a negedge: drive inputs, let one posedge happen, compare at the next negedge.
   task automatic cyc(input logic [3:0] raw, input logic [3:0] a, input logic c);
      beam_raw = raw; ack = a; clear = c;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
      for (int i = 0; i < 4; i++) if (coin_event[i] === 1'b1) ev_tally[i]++;
   endtask

   task automatic hold(input logic [3:0] raw, input int n);
      for (int k = 0; k < n; k++) cyc(raw, 4'h0, 1'b0);
   endtask

   task automatic apply_reset(input int n);
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      for (int k = 0; k < n; k++) cyc(beam_raw, 4'h0, 1'b0);
      rst_n = 1'b1;
   endtask

   int t0;
   logic [3:0] lvl_r;
   int rem[4];

   initial begin
      for (int i = 0; i < 4; i++) ev_tally[i] = 0;
      model_reset();
      #1;
      check("reset_total", total_cents, 32'd0);
      check("reset_count_25", 32'(count_25), 32'd0);
      check("reset_pending", 32'(pending), 32'd0);
      @(negedge clk);
      hold(4'hF, 2);
      rst_n = 1'b1;
      hold(4'hF, 6);

      // Clean 10-cycle pulse on the 25c lane
      for (int k = 0; k < 10; k++) begin
         cyc(4'b0111, 4'h0, 1'b0);
         if (k == 4) check("a_no_early_event", 32'(coin_event), 32'h0);
         if (k == 5) check("a_event_lat6", 32'(coin_event), 32'b1000);
         if (k == 6) begin
            check("a_count_25", 32'(count_25), 32'd1);
            check("a_total", total_cents, 32'd25);
            check("a_pending", 32'(pending), 32'b1000);
         end
      end
      hold(4'hF, 10);
      check("a_single_event", 32'(ev_tally[3]), 32'd1);
      cyc(4'hF, 4'b1000, 1'b0);
      cyc(4'hF, 4'h0, 1'b0);
      check("a_ack_clears", 32'(pending), 32'd0);

      // Glitch then bouncy coin on the 1c lane
      cyc(4'hF, 4'h0, 1'b1);
      hold(4'hF, 2);
      t0 = ev_tally[0];
      hold(4'b1110, 3);
      hold(4'hF, 6);
      check("b_glitch_no_event", 32'(ev_tally[0] - t0), 32'd0);
      hold(4'b1110, 10);
      hold(4'hF, 2); hold(4'b1110, 2); hold(4'hF, 2); hold(4'b1110, 2);
      hold(4'hF, 12);
      check("b_one_event", 32'(ev_tally[0] - t0), 32'd1);
      check("b_count_1", 32'(count_1), 32'd1);
      check("b_total", total_cents, 32'd1);

      // Simultaneous 5c and 10c, then ack colliding with a new 5c event
      cyc(4'hF, 4'hF, 1'b1);
      hold(4'hF, 2);
      for (int k = 0; k < 8; k++) begin
         cyc(4'b1001, 4'h0, 1'b0);
         if (k == 5) check("c_both_events", 32'(coin_event), 32'b0110);
         if (k == 6) check("c_total_15", total_cents, 32'd15);
      end
      hold(4'hF, 10);
      for (int k = 0; k < 8; k++) begin
         cyc(4'b1101, (k == 6) ? 4'b0010 : 4'h0, 1'b0);
         if (k == 6) check("c_pending_set_wins", 32'(pending), 32'b0110);
      end
      hold(4'hF, 10);

      // Saturation of count_1, then clear coincident with an event
      cyc(4'hF, 4'hF, 1'b1);
      hold(4'hF, 2);
      for (int n = 0; n < 17; n++) begin
         hold(4'b1110, 6);
         hold(4'hF, 8);
      end
      check("d_count_1_sat", 32'(count_1), 32'd15);
      check("d_total_17", total_cents, 32'd17);
      for (int k = 0; k < 8; k++) begin
         cyc(4'b1110, 4'h0, k == 6);
         if (k == 6) begin
            check("d_clear_count_1", 32'(count_1), 32'd1);
            check("d_clear_total", total_cents, 32'd1);
         end
      end
      hold(4'hF, 10);

      // Jam on the 10c lane
      cyc(4'hF, 4'hF, 1'b1);
      hold(4'hF, 2);
      t0 = ev_tally[2];
      for (int k = 0; k < 30; k++) begin
         cyc(4'b1011, 4'h0, 1'b0);
         if (k == 24) check("e_jam_not_yet", 32'(jam), 32'h0);
         if (k == 25) check("e_jam_on", 32'(jam), 32'b0100);
      end
      check("e_single_event", 32'(ev_tally[2] - t0), 32'd1);
      for (int k = 0; k < 8; k++) begin
         cyc(4'hF, 4'h0, 1'b0);
         if (k == 4) check("e_jam_held", 32'(jam), 32'b0100);
         if (k == 5) check("e_jam_off", 32'(jam), 32'h0);
      end

      // Reset during the 25c lane's fall check, release with the beam still broken
      hold(4'b0111, 3);
      apply_reset(2);
      check("f_reset_total", total_cents, 32'd0);
      check("f_reset_count_10", 32'(count_10), 32'd0);
      for (int k = 0; k < 8; k++) begin
         cyc(4'b0111, 4'h0, 1'b0);
         if (k == 4) check("f_no_early_event", 32'(coin_event), 32'h0);
         if (k == 5) check("f_event_after_reset", 32'(coin_event), 32'b1000);
      end
      hold(4'hF, 10);

      // Random beam waveforms with bounces, jams, acks, clears and rare resets
      lvl_r = 4'hF;
      for (int i = 0; i < 4; i++) rem[i] = $urandom_range(1, 10);
      for (int n = 0; n < 2000; n++) begin
         for (int i = 0; i < 4; i++) begin
            if (rem[i] == 0) begin
               lvl_r[i] = ~lvl_r[i];
               if ($urandom_range(0, 9) < 3) rem[i] = $urandom_range(1, 3);
               else if ($urandom_range(0, 19) == 0) rem[i] = $urandom_range(22, 35);
               else rem[i] = $urandom_range(4, 12);
            end
            rem[i]--;
         end
         if ($urandom_range(0, 599) == 0) begin
            beam_raw = lvl_r;
            apply_reset(2);
         end else begin
            cyc(lvl_r, ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0,
                $urandom_range(0, 149) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
